// File: rtl/tdm_port.sv
// tdm_port: I2S (MODE 0) / TDM-DSP (MODE 1) serial-audio port with sclk divider, frame marker,
// TX serialiser with ready/valid handshake and RX deserialiser. Define TDM_PORT_LOOPBACK_EN for loopback_in.
module tdm_port #(
  parameter int unsigned MODE          = 0,
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned SLOT_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 24,
  parameter int unsigned MCLK_DIV_SCLK = 4
) (
  input  logic                         mclk_in,
  input  logic                         arstn_in,
`ifdef TDM_PORT_LOOPBACK_EN
  input  logic                         loopback_in,
`endif
  output logic                         sclk_out,
  output logic                         fsync_out,
  input  logic                         sdata_in,
  output logic                         sdata_out,
  output logic [NUM_CH*DATA_WIDTH-1:0] rx_data_out,
  output logic                         rx_valid_out,
  input  logic [NUM_CH*DATA_WIDTH-1:0] tx_data_in,
  input  logic                         tx_valid_in,
  output logic                         tx_ready_out,
  output logic                         tx_underrun_out
);

  localparam int unsigned F     = NUM_CH * SLOT_WIDTH;
  localparam int unsigned W     = NUM_CH * DATA_WIDTH;
  localparam int unsigned HALF  = MCLK_DIV_SCLK / 2;
  localparam int unsigned DIV_W = (MCLK_DIV_SCLK > 2) ? $clog2(MCLK_DIV_SCLK) : 1;
  localparam int unsigned BIT_W = (F > 2) ? $clog2(F) : 1;

  if (MODE > 1) begin : g_bad_mode
    $error("tdm_port: MODE must be 0 or 1");
  end
  if (MODE == 0 && NUM_CH != 2) begin : g_bad_i2s_ch
    $error("tdm_port: NUM_CH must be 2 in I2S mode");
  end
  if (NUM_CH == 0 || F < 2) begin : g_bad_frame
    $error("tdm_port: frame must hold at least two sclk periods");
  end
  if (DATA_WIDTH == 0 || DATA_WIDTH > SLOT_WIDTH) begin : g_bad_width
    $error("tdm_port: DATA_WIDTH must be in 1..SLOT_WIDTH");
  end
  if (MCLK_DIV_SCLK < 2 || (MCLK_DIV_SCLK % 2) != 0) begin : g_bad_div
    $error("tdm_port: MCLK_DIV_SCLK must be even and at least 2");
  end

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_d;
  logic [BIT_W-1:0] r_bit;
  logic [BIT_W-1:0] w_bit_d;
  logic             w_fall;
  logic             w_rise;
  logic             w_load;
  logic             w_frame_end;
  logic             w_sclk_d;
  logic             w_fsync_d;
  logic             w_rx_bit;

  logic             r_sclk;
  logic             r_fsync;
  logic             r_sdata;
  logic [F-1:0]     r_tx_sr;
  logic             r_tx_ready;
  logic             r_tx_underrun;
  logic [F-2:0]     r_rx_sr;
  logic [W-1:0]     r_rx_data;
  logic             r_rx_armed;
  logic             r_rx_upd;
  logic             r_rx_valid;

  logic [F-1:0]     w_tx_frame;
  logic [F-1:0]     w_rx_full;
  logic [W-1:0]     w_rx_data;

  // w_fall/w_rise flag the cycle whose closing edge enters d = 0 / d = DIV/2.
  always_comb begin
    w_fall  = (r_div == DIV_W'(MCLK_DIV_SCLK - 1));
    w_rise  = (r_div == DIV_W'(HALF - 1));
    w_div_d = w_fall ? '0 : r_div + 1'b1;
    w_bit_d = r_bit;
    if (w_fall) begin
      w_bit_d = (r_bit == BIT_W'(F - 1)) ? '0 : r_bit + 1'b1;
    end
    w_load      = w_fall && (w_bit_d == BIT_W'(1));
    w_frame_end = w_rise && (r_bit == '0);
    w_sclk_d    = (w_div_d >= DIV_W'(HALF));
    if (MODE == 0) begin
      w_fsync_d = (w_bit_d >= BIT_W'(SLOT_WIDTH));
    end else begin
      w_fsync_d = (w_bit_d == '0);
    end
  end

`ifdef TDM_PORT_LOOPBACK_EN
  assign w_rx_bit = loopback_in ? r_sdata : sdata_in;
`else
  assign w_rx_bit = sdata_in;
`endif

  // Frame vector bit F-1 is period 1 (slot 0 MSB); bit 0 is period 0 (last bit of the last slot).
  assign w_rx_full = {r_rx_sr, w_rx_bit};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_bit
      assign w_tx_frame[F-1-(c*SLOT_WIDTH+k)]       = tx_data_in[c*DATA_WIDTH+DATA_WIDTH-1-k];
      assign w_rx_data[c*DATA_WIDTH+DATA_WIDTH-1-k] = w_rx_full[F-1-(c*SLOT_WIDTH+k)];
    end
    if (SLOT_WIDTH > DATA_WIDTH) begin : g_pad
      assign w_tx_frame[F-1-c*SLOT_WIDTH-DATA_WIDTH -: SLOT_WIDTH-DATA_WIDTH] = '0;
    end
  end

  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_sclk  <= 1'b0;
      r_fsync <= (MODE == 1);
    end else begin
      r_div   <= w_div_d;
      r_bit   <= w_bit_d;
      r_sclk  <= w_sclk_d;
      r_fsync <= w_fsync_d;
    end
  end

  // TX: load at the fall entering b = 1, otherwise shift on every fall.
  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      r_sdata       <= 1'b0;
      r_tx_sr       <= '0;
      r_tx_ready    <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_tx_ready    <= w_load;
      r_tx_underrun <= w_load & ~tx_valid_in;
      if (w_load) begin
        r_sdata <= tx_valid_in & w_tx_frame[F-1];
        r_tx_sr <= tx_valid_in ? {w_tx_frame[F-2:0], 1'b0} : '0;
      end else if (w_fall) begin
        r_sdata <= r_tx_sr[F-1];
        r_tx_sr <= {r_tx_sr[F-2:0], 1'b0};
      end
    end
  end

  // RX: the first b = 0 rise after reset only arms the capture; its frame is incomplete.
  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
      r_rx_armed <= 1'b0;
      r_rx_upd   <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_upd   <= w_frame_end & r_rx_armed;
      r_rx_valid <= r_rx_upd;
      if (w_rise) begin
        r_rx_sr <= w_rx_full[F-2:0];
      end
      if (w_frame_end) begin
        r_rx_armed <= 1'b1;
        if (r_rx_armed) begin
          r_rx_data <= w_rx_data;
        end
      end
    end
  end

  assign sclk_out        = r_sclk;
  assign fsync_out       = r_fsync;
  assign sdata_out       = r_sdata;
  assign rx_data_out     = r_rx_data;
  assign rx_valid_out    = r_rx_valid;
  assign tx_ready_out    = r_tx_ready;
  assign tx_underrun_out = r_tx_underrun;

endmodule
